// File: rtl/watch_ctrl_unit_pkg.sv
// Shared encodings for the watch control stage: edit-field codes, FSM states
// and the cursor-movement helpers used by the edit FSM.
package watch_ctrl_unit_pkg;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_SEC  = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_HOUR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_EDIT_SEC  = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_EDIT_HOUR = 2'd3
  } state_t;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      ST_EDIT_SEC:  field_of = FIELD_SEC;
      ST_EDIT_MIN:  field_of = FIELD_MIN;
      ST_EDIT_HOUR: field_of = FIELD_HOUR;
      default:      field_of = FIELD_NONE;
    endcase
  endfunction

  // Cursor toward hour, wrapping back to sec.
  function automatic state_t next_left(input state_t s);
    case (s)
      ST_EDIT_SEC:  next_left = ST_EDIT_MIN;
      ST_EDIT_MIN:  next_left = ST_EDIT_HOUR;
      ST_EDIT_HOUR: next_left = ST_EDIT_SEC;
      default:      next_left = s;
    endcase
  endfunction

  // Cursor toward sec, wrapping back to hour.
  function automatic state_t next_right(input state_t s);
    case (s)
      ST_EDIT_HOUR: next_right = ST_EDIT_MIN;
      ST_EDIT_MIN:  next_right = ST_EDIT_SEC;
      ST_EDIT_SEC:  next_right = ST_EDIT_HOUR;
      default:      next_right = s;
    endcase
  endfunction

endpackage

// File: rtl/watch_btn_repeat.sv
// One up/down button: 2-FF synchronizer, rising-edge detect and hold-to-repeat
// counter. o_pulse is a single-cycle strobe; the parent registers it per field.
module watch_btn_repeat #(
  parameter int HOLD_DELAY_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_tick_1ms,
  input  logic i_clear,
  input  logic i_disarm,
  output logic o_pulse,
  output logic o_level
);

  localparam int HW = $clog2(HOLD_DELAY_MS + REPEAT_MS) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_d1;
  logic          r_armed;
  logic          r_rep;
  logic [HW-1:0] r_hold;

  logic          w_edge;
  logic          w_fire;
  logic          w_armed_next;
  logic          w_rep_next;
  logic [HW-1:0] w_hold_next;
  logic [HW-1:0] w_hold_inc;
  logic [HW-1:0] w_target;

  assign w_edge     = r_sync2 & ~r_d1;
  assign w_hold_inc = r_hold + 1'b1;
  assign w_target   = r_rep ? HW'(REPEAT_MS) : HW'(HOLD_DELAY_MS);

  // Repeats need an accepted press; a level that was already high when edit
  // mode started (or when reset released) never auto-repeats.
  always_comb begin
    w_fire       = 1'b0;
    w_hold_next  = r_hold;
    w_rep_next   = r_rep;
    w_armed_next = r_armed;

    if (!r_sync2 || i_disarm)
      w_armed_next = 1'b0;
    else if (w_edge && !i_clear)
      w_armed_next = 1'b1;

    if (!r_sync2 || i_clear) begin
      w_hold_next = '0;
      w_rep_next  = 1'b0;
    end else if (w_edge) begin
      w_fire      = 1'b1;
      w_hold_next = '0;
      w_rep_next  = 1'b0;
    end else if (r_armed && i_tick_1ms) begin
      if (w_hold_inc == w_target) begin
        w_fire      = 1'b1;
        w_hold_next = '0;
        w_rep_next  = 1'b1;
      end else begin
        w_hold_next = w_hold_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_d1    <= 1'b0;
      r_armed <= 1'b0;
      r_rep   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_d1    <= r_sync2;
      r_armed <= w_armed_next;
      r_rep   <= w_rep_next;
      r_hold  <= w_hold_next;
    end
  end

  assign o_pulse = w_fire;
  assign o_level = r_sync2;

endmodule

// File: rtl/watch_ctrl_unit.sv
// Watch control stage: edit-mode FSM with field cursor, and U/D buttons turned
// into single-cycle up/down pulses (with auto-repeat) for the selected field.
module watch_ctrl_unit
  import watch_ctrl_unit_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int HOLD_DELAY_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw_edit,
  input  logic       i_btn_l,
  input  logic       i_btn_r,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  output logic       o_sec_up,
  output logic       o_sec_down,
  output logic       o_min_up,
  output logic       o_min_down,
  output logic       o_hour_up,
  output logic       o_hour_down,
  output logic       o_edit_active,
  output logic [1:0] o_edit_field
);

  localparam int DIV = CLK_FREQ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_presc;
  logic          w_tick;

  // Bit 2 = edit switch, bit 1 = L, bit 0 = R.
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [1:0] r_d1;

  state_t     r_state;
  logic       r_sec_up;
  logic       r_sec_down;
  logic       r_min_up;
  logic       r_min_down;
  logic       r_hour_up;
  logic       r_hour_down;
  logic       r_edit_active;
  logic [1:0] r_edit_field;

  logic       w_sw;
  logic       w_l_edge;
  logic       w_r_edge;
  logic       w_in_edit;
  logic       w_exit;
  logic       w_move;
  logic       w_clear;
  logic       w_disarm;
  logic [1:0] w_btn_ud;
  logic [1:0] w_fire;
  logic [1:0] w_level;

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_presc <= '0;
    else if (w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_d1    <= '0;
    end else begin
      r_sync1 <= {i_sw_edit, i_btn_l, i_btn_r};
      r_sync2 <= r_sync1;
      r_d1    <= r_sync2[1:0];
    end
  end

  assign w_sw      = r_sync2[2];
  assign w_l_edge  = r_sync2[1] & ~r_d1[1];
  assign w_r_edge  = r_sync2[0] & ~r_d1[0];
  assign w_in_edit = (r_state != ST_RUN);
  assign w_exit    = w_in_edit & ~w_sw;
  assign w_move    = w_in_edit & w_sw & (w_l_edge ^ w_r_edge);

  // Leaving edit cancels everything; a cursor move or U+D together only
  // restarts the hold timing.
  assign w_disarm  = ~w_in_edit | w_exit;
  assign w_clear   = w_disarm | w_move | (w_level[0] & w_level[1]);

  // Index 0 = U, index 1 = D; both share the ms prescaler.
  assign w_btn_ud  = {i_btn_d, i_btn_u};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ud
      watch_btn_repeat #(
        .HOLD_DELAY_MS (HOLD_DELAY_MS),
        .REPEAT_MS     (REPEAT_MS)
      ) u_rep (
        .clk        (clk),
        .rst        (rst),
        .i_btn      (w_btn_ud[gi]),
        .i_tick_1ms (w_tick),
        .i_clear    (w_clear),
        .i_disarm   (w_disarm),
        .o_pulse    (w_fire[gi]),
        .o_level    (w_level[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_sec_up      <= 1'b0;
      r_sec_down    <= 1'b0;
      r_min_up      <= 1'b0;
      r_min_down    <= 1'b0;
      r_hour_up     <= 1'b0;
      r_hour_down   <= 1'b0;
      r_edit_active <= 1'b0;
      r_edit_field  <= FIELD_NONE;
    end else begin
      case (r_state)
        ST_RUN: if (w_sw) r_state <= ST_EDIT_SEC;
        default: begin
          if (!w_sw)
            r_state <= ST_RUN;
          else if (w_move)
            r_state <= w_l_edge ? next_left(r_state) : next_right(r_state);
        end
      endcase

      r_sec_up      <= w_fire[0] & (r_state == ST_EDIT_SEC);
      r_sec_down    <= w_fire[1] & (r_state == ST_EDIT_SEC);
      r_min_up      <= w_fire[0] & (r_state == ST_EDIT_MIN);
      r_min_down    <= w_fire[1] & (r_state == ST_EDIT_MIN);
      r_hour_up     <= w_fire[0] & (r_state == ST_EDIT_HOUR);
      r_hour_down   <= w_fire[1] & (r_state == ST_EDIT_HOUR);
      r_edit_active <= w_in_edit;
      r_edit_field  <= field_of(r_state);
    end
  end

  assign o_sec_up      = r_sec_up;
  assign o_sec_down    = r_sec_down;
  assign o_min_up      = r_min_up;
  assign o_min_down    = r_min_down;
  assign o_hour_up     = r_hour_up;
  assign o_hour_down   = r_hour_down;
  assign o_edit_active = r_edit_active;
  assign o_edit_field  = r_edit_field;

endmodule

// File: tb/tb_watch_ctrl_unit.sv
// Directed bench for watch_ctrl_unit with a 1 ms tick every clock,
// HOLD_DELAY_MS=5 and REPEAT_MS=2.
module tb_watch_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic       bl  = 1'b0;
  logic       br  = 1'b0;
  logic       bu  = 1'b0;
  logic       bd  = 1'b0;
  logic       o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down;
  logic       o_edit_active;
  logic [1:0] o_edit_field;
  logic [5:0] pulses;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] P_NONE    = 6'b000000;
  localparam logic [5:0] P_SEC_UP  = 6'b100000;
  localparam logic [5:0] P_SEC_DN  = 6'b010000;
  localparam logic [5:0] P_HOUR_UP = 6'b000010;

  always #5 clk = ~clk;

  watch_ctrl_unit #(
    .CLK_FREQ      (1000),
    .HOLD_DELAY_MS (5),
    .REPEAT_MS     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_sw_edit     (sw),
    .i_btn_l       (bl),
    .i_btn_r       (br),
    .i_btn_u       (bu),
    .i_btn_d       (bd),
    .o_sec_up      (o_sec_up),
    .o_sec_down    (o_sec_down),
    .o_min_up      (o_min_up),
    .o_min_down    (o_min_down),
    .o_hour_up     (o_hour_up),
    .o_hour_down   (o_hour_down),
    .o_edit_active (o_edit_active),
    .o_edit_field  (o_edit_field)
  );

  assign pulses = {o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input int sel, input logic v);
    case (sel)
      0: bl = v;
      1: br = v;
      2: bu = v;
      default: bd = v;
    endcase
  endtask

  // One-clock press; the pulse (if any) must appear on the 3rd edge only.
  task automatic tap(input int sel, input logic [5:0] exp_pulse, input string tag);
    set_btn(sel, 1'b1);
    tick();
    chk(tag, {10'd0, pulses}, {10'd0, P_NONE});
    set_btn(sel, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk(tag, {10'd0, pulses}, {10'd0, (i == 3) ? exp_pulse : P_NONE});
    end
  endtask

  task automatic chk_field(input string tag, input logic [1:0] f);
    chk(tag, {13'd0, o_edit_active, o_edit_field}, {13'd0, (f != 2'b00), f});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    // 1. reset state, idle run mode, U ignored in run mode
    #2 rst = 1'b0;
    idle(3);
    chk("reset_outputs", {7'd0, o_edit_active, o_edit_field, pulses}, 16'd0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_run", {7'd0, o_edit_active, o_edit_field, pulses}, 16'd0);
    end
    bu = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("run_u_ignored", {10'd0, pulses}, {10'd0, P_NONE});
    end
    bu = 1'b0;
    idle(3);

    // 2. enter edit: field decode appears one clk after the state change
    sw = 1'b1;
    idle(3);
    chk_field("enter_edit_lag", 2'b00);
    tick();
    chk_field("enter_edit_sec", 2'b01);
    idle(2);
    tap(2, P_SEC_UP, "tap_u_sec");
    tap(3, P_SEC_DN, "tap_d_sec");

    // 3. cursor moves and wrap
    tap(0, P_NONE, "tap_l1");
    chk_field("field_min", 2'b10);
    tap(0, P_NONE, "tap_l2");
    chk_field("field_hour", 2'b11);
    tap(2, P_HOUR_UP, "tap_u_hour");
    tap(1, P_NONE, "tap_r1");
    chk_field("r_to_min", 2'b10);
    tap(1, P_NONE, "tap_r2");
    chk_field("r_to_sec", 2'b01);
    tap(1, P_NONE, "tap_r3");
    chk_field("r_wrap_hour", 2'b11);

    // 4. back to sec, hold U: pulses at edges 3, 8, 10, 12
    tap(0, P_NONE, "l_wrap_sec");
    chk_field("l_wrap_sec_field", 2'b01);
    bu = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("hold_u_repeat", {10'd0, pulses},
          {10'd0, (i == 3 || i == 8 || i == 10 || i == 12) ? P_SEC_UP : P_NONE});
      if (i == 11) bu = 1'b0;
    end

    // 5. U+D together, L+R together
    bu = 1'b1;
    bd = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("u_and_d", {10'd0, pulses}, {10'd0, P_NONE});
    end
    bl = 1'b1;
    br = 1'b1;
    tick();
    chk("l_and_r", {10'd0, pulses}, {10'd0, P_NONE});
    bl = 1'b0;
    br = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("l_and_r", {10'd0, pulses}, {10'd0, P_NONE});
    end
    chk_field("l_and_r_field", 2'b01);
    bu = 1'b0;
    bd = 1'b0;
    idle(4);

    // exit while holding U: the repeat due at edge 12 is cancelled
    bu = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("exit_while_held", {10'd0, pulses},
          {10'd0, (i == 3 || i == 8 || i == 10) ? P_SEC_UP : P_NONE});
      if (i == 9) sw = 1'b0;
    end
    chk_field("exit_field", 2'b00);
    bu = 1'b0;
    idle(3);

    // 6. reset mid-repeat, then restart with the switch still on
    sw = 1'b1;
    idle(6);
    chk_field("reenter_sec", 2'b01);
    bu = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("pre_reset_hold", {10'd0, pulses},
          {10'd0, (i == 3 || i == 8) ? P_SEC_UP : P_NONE});
    end
    rst = 1'b0;
    #1;
    chk("async_reset", {7'd0, o_edit_active, o_edit_field, pulses}, 16'd0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("post_reset_pulses", {10'd0, pulses}, {10'd0, P_NONE});
      chk_field("post_reset_field", (i >= 4) ? 2'b01 : 2'b00);
    end
    bu = 1'b0;
    idle(3);
    tap(2, P_SEC_UP, "post_reset_tap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
